i2c_sda_omux: RTL and testbench
===============================

Name: i2c_sda_omux

Overview:
- SDA write-side output multiplexer of the I2C slave interface in the myfilter design.
- Selects between the serial data bit being transmitted and the acknowledge bit, qualified by an output enable.
- Presents a registered, open-drain-style SDA drive value (0 = pull SDA low, 1 = release).
- Sits between the I2C slave control FSM / shift register and the SDA pad driver.

Parameters:
- RESET_LEVEL, 1'b1, value of sdaw_out during and after reset (bus released).
- ACK_ACTIVE_HIGH, 1, when 1 ack_in=1 means "send ACK" (SDA driven low); when 0 ack_in is driven to SDA directly.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- oe_in  input  1  output enable; 0 forces SDA released.
- osel_in  input  1  output select; 0 = data (sd_in), 1 = acknowledge (ack_in).
- ack_in  input  1  acknowledge request from control FSM.
- sd_in  input  1  serial data bit from transmit shift register (MSB-first supplied externally).
- sdaw_out  output  1  registered SDA write value; 0 pulls the line low, 1 releases it.

Behaviour:
- Reset: while rst=1, sdaw_out = RESET_LEVEL (1) immediately, independent of clk. Release of rst is asynchronous; the first update occurs on the next rising clk edge.
- Combinational next value nxt:
  - oe_in=0: nxt = 1 (released), regardless of osel_in/ack_in/sd_in.
  - oe_in=1, osel_in=0: nxt = sd_in.
  - oe_in=1, osel_in=1: nxt = ~ack_in if ACK_ACTIVE_HIGH=1, else ack_in.
- sdaw_out <= nxt on every rising clk edge when rst=0. Latency is exactly 1 clock from input change to output. No other state.
- Priority: rst > oe_in > osel_in.
- Simultaneous changes of oe_in/osel_in/data in one cycle resolve purely through the mux above. There are no glitches, because the output is a flop.
- Any X/Z on a selected input propagates to sdaw_out. Inputs that are not selected must not affect the output (e.g. sd_in=X with osel_in=1 gives a clean ack value).
- Reset asserted mid-operation forces sdaw_out=1 within the same cycle. Previous state is not retained.
- No clock gating and no internal counters. The output holds its value while inputs are stable.

Test Plan:
- Reset: assert rst with oe_in=1, osel_in=0, sd_in=0 -> sdaw_out=1 asynchronously. Deassert rst -> sdaw_out=0 after the next rising edge.
- Output disable: oe_in=0, all combinations of osel_in/ack_in/sd_in (8 cases) -> sdaw_out=1 one cycle later in every case.
- Data path: oe_in=1, osel_in=0, drive sd_in pattern 1,0,1,1,0 on consecutive cycles -> sdaw_out shows 1,0,1,1,0 delayed by exactly one cycle.
- Acknowledge path: oe_in=1, osel_in=1, ack_in=1 -> sdaw_out=0. ack_in=0 -> sdaw_out=1. sd_in toggling throughout has no effect.
- Select switch: oe_in=1, sd_in=1, ack_in=1, toggle osel_in 0->1->0 on consecutive edges -> sdaw_out 1,0,1 with one-cycle lag. Then drop oe_in -> 1 next cycle.
- Mid-operation reset: during the data pattern, pulse rst for a half clock between edges -> sdaw_out=1 at once. It resumes tracking sd_in on the first edge after release. The DUT output must match the reference implementation sample-for-sample over 1000 random input cycles.

Source files
------------

// File: rtl/i2c_sda_omux.sv
// SDA write-side output mux for the I2C slave.
// Picks data or ack, gated by output enable, and registers the drive value.
module i2c_sda_omux #(
  parameter logic RESET_LEVEL     = 1'b1,
  parameter bit   ACK_ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic oe_in,
  input  logic osel_in,
  input  logic ack_in,
  input  logic sd_in,
  output logic sdaw_out
);

  logic w_ack;
  logic w_sel;
  logic w_nxt;
  logic r_sdaw;

  // ACK means pulling SDA low, so an active-high request is inverted
  assign w_ack = ACK_ACTIVE_HIGH ? ~ack_in : ack_in;
  assign w_sel = osel_in ? w_ack : sd_in;
  assign w_nxt = oe_in ? w_sel : 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sdaw <= RESET_LEVEL;
    end else begin
      r_sdaw <= w_nxt;
    end
  end

  assign sdaw_out = r_sdaw;

endmodule

// File: tb/tb_i2c_sda_omux.sv
// Scoreboard bench for i2c_sda_omux.
// Stimulus pushes expected SDA values; a monitor pops and compares after each edge.
module tb_i2c_sda_omux;

  logic clk;
  logic rst;
  logic oe_in;
  logic osel_in;
  logic ack_in;
  logic sd_in;
  logic sdaw_out;

  int   checks;
  int   errors;
  logic q[$];

  i2c_sda_omux dut (
    .clk      (clk),
    .rst      (rst),
    .oe_in    (oe_in),
    .osel_in  (osel_in),
    .ack_in   (ack_in),
    .sd_in    (sd_in),
    .sdaw_out (sdaw_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_sda(
    input logic oe, input logic osel,
    input logic ack, input logic sd
  );
    case ({oe, osel})
      2'b10:   return sd;
      2'b11:   return ~ack;
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", nm, act, req, $time);
    end
  endtask

  task automatic drive(
    input logic oe, input logic osel,
    input logic ack, input logic sd
  );
    oe_in   = oe;
    osel_in = osel;
    ack_in  = ack;
    sd_in   = sd;
    q.push_back(ref_sda(oe, osel, ack, sd));
  endtask

  task automatic step(
    input logic oe, input logic osel,
    input logic ack, input logic sd
  );
    @(negedge clk);
    drive(oe, osel, ack, sd);
  endtask

  // half-clock reset pulse in the low phase, released before the edge
  task automatic step_rst(
    input logic oe, input logic osel,
    input logic ack, input logic sd
  );
    @(negedge clk);
    drive(oe, osel, ack, sd);
    #1 rst = 1'b1;
    #1 chk("midrst_async", sdaw_out, 1'b1);
    #1 rst = 1'b0;
  endtask

  initial begin : monitor
    logic e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("sb", sdaw_out, e);
      end
    end
  end

  initial begin : stim
    logic [4:0] pat;
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    oe_in   = 1'b1;
    osel_in = 1'b0;
    ack_in  = 1'b0;
    sd_in   = 1'b0;
    #1 chk("reset_level", sdaw_out, 1'b1);

    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    #1 chk("hold_until_edge", sdaw_out, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_assert", sdaw_out, 1'b1);
    #1 rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, i[2], i[1], i[0]);
    end

    pat = 5'b10110;
    for (int i = 4; i >= 0; i--) begin
      step(1'b1, 1'b0, 1'b0, pat[i]);
    end

    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);

    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);

    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step_rst(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        step_rst($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end else begin
        step($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
      end
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(posedge clk);
      #2;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
